// File: rtl/fa_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// slice width and the nibble-counter width helper.
package fa_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes nibbles 0..nibbles-1; never narrower than 1 bit.
    function automatic int cnt_width(input int nibbles);
        if (nibbles <= 2) begin
            return 1;
        end
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit adder slice with carry in/out, shared across all
// nibbles of a wide addition.
module add4_slice
    import fa_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/fa_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one add4_slice is reused LSB nibble first,
// with the inter-nibble carry kept in a register.
module fa_serial_add_ctrl
    import fa_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int CW      = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic              carry_reg, carry_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  s_reg, s_next;
    logic              co_reg, co_next;
    logic              accept;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_co;

    assign sl_a = a_reg[SLICE_W*cnt_reg +: SLICE_W];
    assign sl_b = b_reg[SLICE_W*cnt_reg +: SLICE_W];

    add4_slice u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_reg),
        .s  (sl_s),
        .co (sl_co)
    );

    // Each result nibble is cleared on an accepted start and written only in
    // the RUN cycle whose counter selects it; otherwise it holds.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        logic nib_we;
        assign nib_we = (state_reg == RUN) && (cnt_reg == CW'(gi));
        assign s_next[SLICE_W*gi +: SLICE_W] =
            accept ? {SLICE_W{1'b0}} :
            nib_we ? sl_s            :
                     s_reg[SLICE_W*gi +: SLICE_W];
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        co_next    = co_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                    a_next     = a;
                    b_next     = b;
                    carry_next = ci;
                    cnt_next   = '0;
                    co_next    = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                carry_next = sl_co;
                if (cnt_reg == LAST_CNT) begin
                    co_next    = sl_co;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            co_reg    <= co_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign s    = s_reg;
    assign co   = co_reg;

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Scoreboard bench for fa_serial_add_ctrl: directed operations push expected
// {co,s}; monitors pop and compare on every done pulse (16-bit and 8-bit DUTs).
module tb_fa_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start, start8;
    logic [15:0] a, b;
    logic [7:0]  a8, b8;
    logic        ci, ci8;
    logic        busy, done, co;
    logic        busy8, done8, co8;
    logic [15:0] s;
    logic [7:0]  s8;

    logic [16:0] exp_q[$];
    logic [8:0]  exp8_q[$];
    logic [16:0] e16;
    logic [8:0]  e8;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done8_cnt = 0;

    fa_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co)
    );

    fa_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitors: one per DUT, popping the scoreboard on each done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e16 = exp_q.pop_front();
                $display("txn16 s=0x%04h co=%0b expected s=0x%04h co=%0b", s, co, e16[15:0], e16[16]);
                check("sum16", {15'd0, co, s}, {15'd0, e16});
                check("done_busy16", {31'd0, busy}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8) begin
            done8_cnt++;
            if (exp8_q.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = exp8_q.pop_front();
                $display("txn8 s=0x%02h co=%0b expected s=0x%02h co=%0b", s8, co8, e8[7:0], e8[8]);
                check("sum8", {23'd0, co8, s8}, {23'd0, e8});
            end
        end
    end

    // Issue one 16-bit op from a point just after a rising edge; returns in the done cycle.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        input logic [16:0] ev);
        int n;
        int nb;
        a = av; b = bv; ci = civ; start = 1'b1;
        exp_q.push_back(ev);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        check("latency16", n, 5);
        check("busy_cycles16", nb, 4);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                       input logic [8:0] ev);
        int n;
        int nb;
        a8 = av; b8 = bv; ci8 = civ; start8 = 1'b1;
        exp8_q.push_back(ev);
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1; nb = 0;
        while (!done8 && n < 20) begin
            if (busy8) nb++;
            @(posedge clk); #1;
            n++;
        end
        check("latency8", n, 3);
        check("busy_cycles8", nb, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_co", {31'd0, co}, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_s8", {24'd0, s8}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic add, then outputs hold while idle despite input changes
        op16(16'h1234, 16'h4321, 1'b0, 17'h05555);
        repeat (2) @(posedge clk);
        #1;
        a = 16'hABCD; b = 16'h1111; ci = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_s", {16'd0, s}, 32'h5555);
        check("hold_co", {31'd0, co}, 32'd0);

        // 2, 3: full-width carry ripple, then no stale carry
        op16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        op16(16'h0000, 16'h0000, 1'b0, 17'h00000);
        @(posedge clk); #1;

        // 4: start pulse during RUN cycle 2 must be ignored
        d0 = done_cnt;
        a = 16'h00F0; b = 16'h0010; ci = 1'b0; start = 1'b1;
        exp_q.push_back(17'h00100);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_dones", done_cnt - d0, 1);

        // 5: reset mid-RUN aborts, then a fresh op behaves normally
        a = 16'h1234; b = 16'h4321; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_s", {16'd0, s}, 32'd0);
        check("abort_co", {31'd0, co}, 32'd0);
        op16(16'h0007, 16'h0009, 1'b0, 17'h00010);
        @(posedge clk); #1;

        // 6: start held high -> back-to-back ops, done every 5 cycles
        d0 = done_cnt;
        a = 16'h8000; b = 16'h8000; ci = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(17'h10000);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done && n < 20);
            check("b2b_interval", n, 5);
            if (k == 2) start = 1'b0;
        end
        repeat (8) @(posedge clk);
        #1;
        check("b2b_dones", done_cnt - d0, 3);

        // WIDTH=8 rerun of case 1
        op8(8'h12, 8'h34, 1'b0, 9'h046);
        op8(8'hFF, 8'h01, 1'b1, 9'h101);
        repeat (3) @(posedge clk);
        #1;

        check("queue16_empty", exp_q.size(), 0);
        check("queue8_empty", exp8_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
